fnd_scan_decoder: RTL and testbench

FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

---
 rtl/fnd_pkg.sv | 31 +++
 rtl/seg7_decode.sv | 31 +++
 rtl/fnd_scan_decoder.sv | 124 ++++++++++++
 tb/tb_fnd_scan_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared FND scan definitions: active-low segment codes, digit-select codes
// and the scan FSM state encoding.
package fnd_pkg;

  // Segment patterns, active-low {dp,g,f,e,d,c,b,a}, dp off
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [3:0] COM_D0 = 4'b1110;
  localparam logic [3:0] COM_D1 = 4'b1101;
  localparam logic [3:0] COM_D2 = 4'b1011;
  localparam logic [3:0] COM_D3 = 4'b0111;

  typedef logic [1:0] fnd_state_t;
  localparam fnd_state_t ST_IDLE   = 2'd0;
  localparam fnd_state_t ST_SETTLE = 2'd1;
  localparam fnd_state_t ST_HOLD   = 2'd2;

  function automatic logic com_is_valid(input logic [3:0] com);
    return (com == COM_D0) || (com == COM_D1) || (com == COM_D2) || (com == COM_D3);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Active-low 7-segment pattern to BCD digit; dp is ignored, unknown patterns miss.
module seg7_decode
  import fnd_pkg::*;
(
  input  logic [7:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_hit
);

  logic [7:0] w_pat;
  assign w_pat = i_seg | 8'h80;

  always_comb begin
    o_digit = 4'd0;
    o_hit   = 1'b1;
    case (w_pat)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Recovers the sec/hundredths value from a multiplexed 4-digit FND drive by
// waiting for each digit select to settle, sampling it, and assembling frames.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned STALE_CYC  = 1_000_000
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fnd_com,
  input  logic [7:0] fnd_data,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       stale
);

  localparam int unsigned   STW         = $clog2(STALE_CYC + 1);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC);
  localparam logic [STW-1:0] STALE_MAX  = STW'(STALE_CYC);

  fnd_state_t       r_state, w_state_nxt;
  logic [3:0]       r_code;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             w_sample;
  logic [3:0]       r_mask, w_mask_nxt;
  logic             r_bad, w_bad_nxt;
  logic [3:0][3:0]  r_dig, w_dig;
  logic [STW-1:0]   r_stale_cnt, w_stale_nxt;
  logic             w_com_ok;
  logic [1:0]       w_idx;
  logic [3:0]       w_dec_digit;
  logic             w_dec_hit;
  logic             w_done, w_frame_ok;
  logic [6:0]       w_msec7, w_sec7;

  seg7_decode u_dec (
    .i_seg   (fnd_data),
    .o_digit (w_dec_digit),
    .o_hit   (w_dec_hit)
  );

  assign w_com_ok = com_is_valid(fnd_com);

  always_comb begin
    w_idx = 2'd0;
    case (fnd_com)
      COM_D1:  w_idx = 2'd1;
      COM_D2:  w_idx = 2'd2;
      COM_D3:  w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // A new valid code (from any state) counts as the first settled cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sample    = 1'b0;
    if (!w_com_ok) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 8'd0;
    end else if (r_state == ST_IDLE || fnd_com != r_code) begin
      w_state_nxt = ST_SETTLE;
      w_cnt_nxt   = 8'd1;
    end else if (r_state == ST_SETTLE) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
    if (w_state_nxt == ST_SETTLE && w_cnt_nxt == SETTLE_LAST) begin
      w_sample    = 1'b1;
      w_state_nxt = ST_HOLD;
    end
  end

  always_comb begin
    w_dig = r_dig;
    if (w_sample) w_dig[w_idx] = w_dec_digit;
  end

  assign w_mask_nxt = r_mask | (w_sample ? ~fnd_com : 4'b0000);
  assign w_bad_nxt  = r_bad | (w_sample & ~w_dec_hit);
  assign w_done     = w_sample && (w_mask_nxt == 4'b1111);
  assign w_msec7    = 7'(w_dig[1]) * 7'd10 + 7'(w_dig[0]);
  assign w_sec7     = 7'(w_dig[3]) * 7'd10 + 7'(w_dig[2]);
  assign w_frame_ok = w_done && !w_bad_nxt && (w_sec7 <= 7'd59);

  assign w_stale_nxt = w_frame_ok ? '0 :
                       (r_stale_cnt == STALE_MAX) ? r_stale_cnt : r_stale_cnt + STW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_code      <= 4'hF;
      r_cnt       <= '0;
      r_mask      <= '0;
      r_bad       <= 1'b0;
      r_dig       <= '0;
      r_stale_cnt <= '0;
      msec        <= '0;
      sec         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      stale       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_com_ok) r_code <= fnd_com;
      r_dig       <= w_dig;
      r_mask      <= w_done ? 4'b0000 : w_mask_nxt;
      r_bad       <= w_done ? 1'b0 : w_bad_nxt;
      frame_valid <= w_frame_ok;
      frame_err   <= w_done & ~w_frame_ok;
      if (w_frame_ok) begin
        msec <= w_msec7;
        sec  <= w_sec7[5:0];
      end
      r_stale_cnt <= w_stale_nxt;
      stale       <= (w_stale_nxt == STALE_MAX);
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench: a run-length model of the scanned display predicts frame
// events; a monitor pops them whenever the decoder pulses.
module tb_fnd_scan_decoder;

  localparam int SETTLE = 4;
  localparam int STALE  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fnd_com = 4'hF;
  logic [7:0] fnd_data = 8'hFF;
  logic [6:0] msec;
  logic [5:0] sec;
  logic       frame_valid, frame_err, stale;

  fnd_scan_decoder #(.SETTLE_CYC(SETTLE), .STALE_CYC(STALE)) dut (
    .clk(clk), .rst(rst), .fnd_com(fnd_com), .fnd_data(fnd_data),
    .msec(msec), .sec(sec), .frame_valid(frame_valid), .frame_err(frame_err), .stale(stale)
  );

  always #5 clk = ~clk;

  typedef struct { bit ok; int ms; int s; } exp_t;
  exp_t q[$];
  int n_checks = 0, n_err = 0;

  // Active-low digit patterns (dp off) for 0..9
  logic [7:0] seg_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [3:0] codes[6]    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1100};

  logic [3:0] m_prev;
  int m_run, m_ms, m_s, m_idle;
  int m_dig[4];
  bit [3:0] m_mask;
  bit m_bad;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [7:0] p);
    for (int k = 0; k < 10; k++) if (p[6:0] == seg_tab[k][6:0]) return k;
    return -1;
  endfunction

  function automatic int slot_of(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = 4'hF; m_run = 0; m_ms = 0; m_s = 0; m_idle = 0;
    m_mask = '0; m_bad = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    q.delete();
  endtask

  // A digit is sampled on the cycle its code has been steady SETTLE times in a row.
  task automatic model_step(input logic [3:0] c, input logic [7:0] d);
    int sl, v, ms, s;
    bit fv;
    fv = 0;
    if (c == m_prev) m_run++; else begin m_run = 1; m_prev = c; end
    sl = slot_of(c);
    if (sl >= 0 && m_run == SETTLE) begin
      v = dec(d);
      if (v < 0) begin m_bad = 1; v = 0; end
      m_dig[sl] = v;
      m_mask[sl] = 1'b1;
      if (m_mask == 4'hF) begin
        ms = m_dig[1] * 10 + m_dig[0];
        s  = m_dig[3] * 10 + m_dig[2];
        if (!m_bad && s <= 59) begin
          m_ms = ms; m_s = s; fv = 1;
          q.push_back('{1'b1, ms, s});
        end else q.push_back('{1'b0, m_ms, m_s});
        m_mask = '0; m_bad = 0;
      end
    end
    m_idle = fv ? 0 : (m_idle < STALE ? m_idle + 1 : STALE);
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic tick(input logic [3:0] c, input logic [7:0] d);
    fnd_com = c; fnd_data = d;
    model_step(c, d);
    @(posedge clk);
    @(negedge clk);
    chk("msec", msec, m_ms);
    chk("sec", sec, m_s);
    chk("stale", stale, (m_idle == STALE) ? 1 : 0);
  endtask

  task automatic hold(input logic [3:0] c, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) tick(c, d);
  endtask

  task automatic scan(input int d3, input int d2, input int d1, input int d0, input int n);
    hold(4'b1110, seg_tab[d0], n);
    hold(4'b1101, seg_tab[d1], n);
    hold(4'b1011, seg_tab[d2], n);
    hold(4'b0111, seg_tab[d3], n);
    hold(4'b1111, 8'hFF, 2);
  endtask

  task automatic do_reset(input int n);
    #2 rst = 1'b0;
    #1;
    chk("rst_msec", msec, 0);
    chk("rst_sec", sec, 0);
    chk("rst_valid", frame_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_stale", stale, 0);
    repeat (n) @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b1 && (frame_valid !== 1'b0 || frame_err !== 1'b0)) begin
      n_checks++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b with no frame expected at %0t",
                 frame_valid, frame_err, $time);
      end else begin
        e = q.pop_front();
        if (frame_valid !== e.ok || frame_err !== !e.ok || msec !== 7'(e.ms) || sec !== 6'(e.s)) begin
          n_err++;
          $display("FAIL frame_event: got valid=%0b err=%0b msec=%0d sec=%0d, expected valid=%0b err=%0b msec=%0d sec=%0d at %0t",
                   frame_valid, frame_err, msec, sec, e.ok, !e.ok, e.ms, e.s, $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset(3);

    // basic frame 23.47
    scan(2, 3, 4, 7, 8);
    chk("scan_msec", msec, 47);
    chk("scan_sec", sec, 23);

    // blank pattern on digit 3 discards the frame
    hold(4'b1110, seg_tab[1], 8);
    hold(4'b1101, seg_tab[1], 8);
    hold(4'b1011, seg_tab[1], 8);
    hold(4'b0111, 8'hFF, 8);
    hold(4'b1111, 8'hFF, 2);
    chk("blank_keep_msec", msec, 47);
    chk("blank_keep_sec", sec, 23);

    // seconds out of range
    scan(7, 5, 0, 0, 8);
    chk("sec75_keep_msec", msec, 47);
    chk("sec75_keep_sec", sec, 23);

    // digit 0 held one cycle short: must not fill its slot
    hold(4'b1110, seg_tab[5], SETTLE - 1);
    hold(4'b1111, 8'hFF, 3);
    hold(4'b1101, seg_tab[6], 8);
    hold(4'b1011, seg_tab[1], 8);
    hold(4'b0111, seg_tab[3], 8);
    hold(4'b1111, 8'hFF, 3);
    hold(4'b1110, seg_tab[9], 8);
    hold(4'b1111, 8'hFF, 2);
    chk("short_msec", msec, 69);
    chk("short_sec", sec, 31);

    // randomized scanning, including odd codes, junk patterns and dp noise
    for (int i = 0; i < 300; i++) begin
      logic [3:0] c;
      logic [7:0] d;
      int r;
      r = $urandom_range(0, 99);
      c = (r < 85) ? codes[$urandom_range(0, 3)] : codes[$urandom_range(4, 5)];
      r = $urandom_range(0, 99);
      if (r < 10) d = 8'($urandom);
      else begin
        d = seg_tab[$urandom_range(0, 9)];
        d[7] = 1'($urandom);
      end
      hold(c, d, $urandom_range(1, 8));
    end
    hold(4'b1111, 8'hFF, 3);

    // frozen scan goes stale; the next good frame clears it
    do_reset(2);
    hold(4'b1110, seg_tab[0], STALE + 10);
    chk("stale_set", stale, 1);
    scan(1, 2, 5, 0, 8);
    chk("stale_clear", stale, 0);
    chk("after_stale_msec", msec, 50);
    chk("after_stale_sec", sec, 12);

    // reset in the middle of a frame drops the partial digits
    hold(4'b1110, seg_tab[3], 8);
    hold(4'b1101, seg_tab[8], 8);
    do_reset(2);
    scan(4, 5, 6, 1, 8);
    chk("post_rst_msec", msec, 61);
    chk("post_rst_sec", sec, 45);

    hold(4'b1111, 8'hFF, 4);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
